// File: rtl/incline_filter_if.sv
// Inertial incline bus: raw sample and strobe in, filtered incline and status flags out.
interface incline_filter_if;
    logic signed [12:0] incline;
    logic               vld;
    logic signed [9:0]  filt_incline;
    logic               filt_vld;
    logic               stale;
    logic               uphill;

    modport master (
        output incline, vld,
        input  filt_incline, filt_vld, stale, uphill
    );

    modport slave (
        input  incline, vld,
        output filt_incline, filt_vld, stale, uphill
    );
endinterface

// File: rtl/incline_filter.sv
// Saturating EMA filter for the raw incline, with stale-data timeout and a
// hysteretic uphill flag.
module incline_filter #(
    parameter int               SHIFT   = 3,
    parameter int               TIMEOUT = 1_000_000,
    parameter logic signed [9:0] UP_ON  = 10'sd96,
    parameter logic signed [9:0] UP_OFF = 10'sd64
) (
    input  logic             clk,
    input  logic             rst_n,
    incline_filter_if.slave  bus
);

    localparam int ACC_W = 11 + SHIFT;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_STALE} state_e;

    state_e                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]         idle_q, idle_d;
    logic                     filt_vld_q, filt_vld_d;
    logic                     stale_q, stale_d;
    logic                     uphill_q, uphill_d;

    logic signed [9:0]        sat;
    logic signed [ACC_W-1:0]  sat_ext;
    logic signed [9:0]        filt_d;
    logic                     timeout_hit;

    always_comb begin
        if (bus.incline > 13'sd511)
            sat = 10'sd511;
        else if (bus.incline < -13'sd512)
            sat = -10'sd512;
        else
            sat = bus.incline[9:0];
    end

    assign sat_ext = ACC_W'(sat);

    // Idle counter saturates so a long silence cannot wrap back into RUN.
    always_comb begin
        if (bus.vld)
            idle_d = '0;
        else if (idle_q == CNT_MAX)
            idle_d = idle_q;
        else
            idle_d = idle_q + 1'b1;
    end

    assign timeout_hit = !bus.vld && (idle_d == CNT_MAX);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        stale_d    = stale_q;
        uphill_d   = uphill_q;
        filt_vld_d = bus.vld;

        unique case (state_q)
            ST_INIT, ST_STALE: begin
                if (bus.vld) begin
                    acc_d   = sat_ext <<< SHIFT;
                    stale_d = 1'b0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.vld) begin
                    acc_d = acc_q - (acc_q >>> SHIFT) + sat_ext;
                end else if (timeout_hit) begin
                    stale_d = 1'b1;
                    state_d = ST_STALE;
                end
            end
            default: state_d = ST_INIT;
        endcase

        // Selecting bits [SHIFT+9:SHIFT] is the floor shift truncated to 10 bits.
        filt_d = $signed(acc_d[SHIFT +: 10]);
        if (bus.vld) begin
            if (filt_d >= UP_ON)
                uphill_d = 1'b1;
            else if (filt_d < UP_OFF)
                uphill_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            acc_q      <= '0;
            idle_q     <= '0;
            filt_vld_q <= 1'b0;
            stale_q    <= 1'b1;
            uphill_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            idle_q     <= idle_d;
            filt_vld_q <= filt_vld_d;
            stale_q    <= stale_d;
            uphill_q   <= uphill_d;
        end
    end

    assign bus.filt_incline = $signed(acc_q[SHIFT +: 10]);
    assign bus.filt_vld     = filt_vld_q;
    assign bus.stale        = stale_q;
    assign bus.uphill       = uphill_q;

endmodule

// File: tb/tb_incline_filter.sv
// Directed bench for incline_filter: a queue of expected results is checked by
// a monitor on every filt_vld pulse, plus direct checks of reset, hold and timeout.
module tb_incline_filter;

    typedef struct {
        int filt;
        bit stale;
        bit up;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    incline_filter_if bus();

    incline_filter #(
        .SHIFT   (3),
        .TIMEOUT (16),
        .UP_ON   (10'sd96),
        .UP_OFF  (10'sd64)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every filt_vld pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && bus.filt_vld === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_filt_vld", 1, 0);
            end else begin
                e = sb.pop_front();
                check("filt_incline", int'(bus.filt_incline), e.filt);
                check("stale_on_vld", int'(bus.stale), int'(e.stale));
                check("uphill_on_vld", int'(bus.uphill), int'(e.up));
            end
        end
    end

    task automatic send(input int inc, input int e_filt, input bit e_stale, input bit e_up);
        exp_t e;
        @(negedge clk);
        bus.incline = 13'(inc);
        bus.vld     = 1'b1;
        e.filt  = e_filt;
        e.stale = e_stale;
        e.up    = e_up;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.vld     = 1'b0;
            bus.incline = '0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        bus.vld     = 1'b0;
        bus.incline = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.vld     = 1'b0;
        bus.incline = '0;
        do_reset();

        check("rst_filt", int'(bus.filt_incline), 0);
        check("rst_filt_vld", int'(bus.filt_vld), 0);
        check("rst_stale", int'(bus.stale), 1);
        check("rst_uphill", int'(bus.uphill), 0);

        // Basic reload from INIT, single-cycle strobe, hold afterwards.
        send(200, 200, 1'b0, 1'b1);
        idle(2);
        check("filt_vld_one_cycle", int'(bus.filt_vld), 0);
        check("filt_hold", int'(bus.filt_incline), 200);

        // Saturation at both ends, then a negative floor step.
        do_reset();
        send(4095, 511, 1'b0, 1'b1);
        idle(2);
        do_reset();
        send(-4096, -512, 1'b0, 1'b0);
        send(512, -385, 1'b0, 1'b0);
        idle(2);

        // EMA steps.
        do_reset();
        send(0, 0, 1'b0, 1'b0);
        send(80, 10, 1'b0, 1'b0);
        send(80, 18, 1'b0, 1'b0);
        idle(2);

        // Hysteresis including exact threshold values.
        do_reset();
        send(100, 100, 1'b0, 1'b1);
        send(-60, 80, 1'b0, 1'b1);
        send(-80, 60, 1'b0, 1'b0);
        send(220, 80, 1'b0, 1'b0);
        send(208, 96, 1'b0, 1'b1);
        send(-160, 64, 1'b0, 1'b1);
        send(56, 63, 1'b0, 1'b0);
        idle(2);

        // Timeout: 15 idle edges still fresh, 16th sets stale.
        do_reset();
        send(200, 200, 1'b0, 1'b1);
        idle(16);
        check("stale_at_15_idle", int'(bus.stale), 0);
        idle(1);
        check("stale_at_16_idle", int'(bus.stale), 1);
        check("stale_filt_hold", int'(bus.filt_incline), 200);
        check("stale_uphill_hold", int'(bus.uphill), 1);
        send(40, 40, 1'b0, 1'b0);
        idle(15);
        send(40, 40, 1'b0, 1'b0);
        send(120, 50, 1'b0, 1'b0);
        idle(2);
        check("vld_wins_stale", int'(bus.stale), 0);

        // Asynchronous reset between clock edges.
        do_reset();
        send(200, 200, 1'b0, 1'b1);
        idle(3);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_filt", int'(bus.filt_incline), 0);
        check("async_rst_filt_vld", int'(bus.filt_vld), 0);
        check("async_rst_stale", int'(bus.stale), 1);
        check("async_rst_uphill", int'(bus.uphill), 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        check("init_stale_held", int'(bus.stale), 1);
        send(30, 30, 1'b0, 1'b0);
        idle(2);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
